rnn_seq_ctrl: RTL
=================

Name: rnn_seq_ctrl

Overview:
- Sequencer and configuration arbiter for the 3-input / 4-hidden / 2-output Q6.12 recurrent datapath.
- Accepts one input vector per timestep over a valid/ready handshake and drives the datapath step index, first-step select and state-register enable.
- After the last step, captures Y0/Y1 into a held output handshake.
- Serialises coefficient/LUT writes (W, B, C, tanh) into the datapath memories, only while no inference is in flight.

Parameters:
- DATA_W, 18, datapath word width (Q6.12).
- NUM_STEPS, 4, timesteps per inference sequence.
- STEP_W, 2, width of the step index (clog2 NUM_STEPS).
- CFG_AW, 7, config address width (covers the 128-entry tanh LUT).
- TIMEOUT_CYC, 255, idle-cycle limit inside a sequence (optional feature only).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  input vector accepted this cycle when in_valid is also high.
- in_u  in  3*DATA_W  {U2,U1,U0}.
- dp_u  out  3*DATA_W  combinational pass-through of in_u to the datapath.
- dp_en  out  1  datapath state-register (x) update enable; equals in_valid&&in_ready.
- dp_first  out  1  high when the accepted vector is step 0 (datapath skips tanh feedback).
- dp_step  out  STEP_W  weight-bank index n for the current step.
- dp_y  in  2*DATA_W  {Y1,Y0} combinational datapath outputs.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed.
- out_y  out  2*DATA_W  registered {Y1,Y0}.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write accepted.
- cfg_sel  in  2  target memory: 0=W(64), 1=B(12), 2=C(8), 3=TANH(128).
- cfg_addr  in  CFG_AW  word address.
- cfg_data  in  DATA_W  write data.
- mem_we  out  4  one-hot write strobe per memory, registered.
- mem_addr  out  CFG_AW  registered address.
- mem_data  out  DATA_W  registered data.
- cfg_err  out  1  one-cycle pulse: out-of-range address was dropped.
- seq_done_cnt  out  16  completed sequences, wraps at 0xFFFF to 0.

Behaviour:
- Reset: state=IDLE, step count=0, out_valid=0, out_y=0, mem_we=0, mem_addr=0, mem_data=0, cfg_err=0, seq_done_cnt=0.
- Reset mid-sequence discards the partial sequence; no output is produced.
- States: IDLE, STEP, CAPTURE, OUT.
- IDLE
  - cfg has priority: if cfg_valid, then cfg_ready=1 and in_ready=0.
  - Otherwise in_ready=1 and cfg_ready=0.
  - Handshake in IDLE: dp_first=1, dp_step=0, cnt<=1, go to STEP (when NUM_STEPS=1, go directly to CAPTURE).
- STEP
  - in_ready=1, cfg_ready=0, dp_step=cnt, dp_first=0.
  - Each handshake increments cnt.
  - Handshake with cnt==NUM_STEPS-1: cnt<=0, go to CAPTURE.
  - No handshake: hold; the datapath x registers are not touched (dp_en=0).
- CAPTURE
  - One cycle; x has been updated, so dp_y is valid.
  - out_y<=dp_y; seq_done_cnt+=1; go to OUT.
  - in_ready=0, cfg_ready=0.
- OUT
  - out_valid=1; out_y stable until out_ready.
  - On out_ready: out_valid<=0, go to IDLE.
  - in_ready=0 and cfg_ready=0 throughout; no back-to-back overlap.
- Latency: out_valid rises 2 clk edges after the final input handshake edge.
- Config write
  - On cfg_valid&&cfg_ready: next cycle mem_we[cfg_sel]=1 with mem_addr/mem_data = captured values.
  - Address must be below the depth of the selected memory (64/12/8/128). Otherwise mem_we stays 0 and cfg_err pulses for 1 cycle.
  - Writes are never accepted outside IDLE.
- dp_en, dp_first and dp_step are combinational from state and the handshake. They are driven to 0 when dp_en=0.

Optional Feature:
- Macro SEQ_TIMEOUT_EN.
- Defined:
  - 8-bit idle counter in STEP, cleared on each handshake.
  - Reaching TIMEOUT_CYC aborts the sequence: go to IDLE, cnt=0, no output.
  - Extra output port err_timeout pulses high for 1 cycle.
- Undefined: no counter and no err_timeout port; STEP waits indefinitely.

Decomposition:
- Package rnn_pkg holds:
  - DATA_W and FRAC_W=12.
  - The state enum {IDLE, STEP, CAPTURE, OUT}.
  - cfg_sel codes CFG_W/CFG_B/CFG_C/CFG_TANH.
  - Memory depth constants 64/12/8/128.
- One sub-module, rnn_cfg_decode: range check plus registered one-hot mem_we/addr/data and cfg_err.

Test Plan:
- Write W[5]=0x01000 (cfg_sel=0, addr=5) -> next cycle mem_we=4'b0001, mem_addr=5, mem_data=0x01000, cfg_err=0.
- Write B addr=12 -> mem_we=0, cfg_err pulses 1 cycle; C addr=7 accepted, mem_we=4'b0100.
- 4 back-to-back vectors with in_valid held high -> dp_step 0,1,2,3, dp_first only on the first, dp_en on 4 cycles.
  - out_valid 2 edges after the 4th handshake; out_y equals dp_y sampled in CAPTURE; seq_done_cnt=1.
- out_ready held low 10 cycles -> out_valid and out_y stable, in_ready=0, cfg_ready=0; release -> IDLE next cycle.
- cfg_valid and in_valid both high in IDLE -> cfg accepted, in_ready=0; vector accepted the following cycle.
- Reset asserted after 2 of 4 steps -> out_valid stays 0, next sequence starts at dp_step=0 with dp_first=1.
  - With SEQ_TIMEOUT_EN: stall 255 cycles in STEP -> err_timeout pulse, return to IDLE.

Source files
------------

// File: rtl/rnn_pkg.sv
// rnn_pkg: shared types, select codes and memory depths for the RNN sequencer.
package rnn_pkg;
    localparam int DATA_W = 18;
    localparam int FRAC_W = 12;
    typedef enum logic [1:0] {IDLE, STEP, CAPTURE, OUT} state_t;
    localparam logic [1:0] CFG_W = 2'd0, CFG_B = 2'd1, CFG_C = 2'd2, CFG_TANH = 2'd3;
    localparam logic [7:0] DEPTH_W = 8'd64, DEPTH_B = 8'd12, DEPTH_C = 8'd8, DEPTH_TANH = 8'd128;
    function automatic logic [7:0] mem_depth(input logic [1:0] sel);
        return sel == CFG_W ? DEPTH_W : sel == CFG_B ? DEPTH_B : sel == CFG_C ? DEPTH_C : DEPTH_TANH;
    endfunction
endpackage

// File: rtl/rnn_cfg_decode.sv
// rnn_cfg_decode: range-checks an accepted config write and registers the
// one-hot memory strobe, address, data and the drop-error pulse.
module rnn_cfg_decode #(
    parameter int DATA_W = 18,
    parameter int CFG_AW = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_fire,
    input  logic [1:0]        i_sel,
    input  logic [CFG_AW-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    output logic [3:0]        o_we,
    output logic [CFG_AW-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_err
);
    import rnn_pkg::*;
    logic              w_ok;
    logic [3:0]        r_we;
    logic [CFG_AW-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_err;
    assign w_ok   = {1'b0, i_addr} < (CFG_AW + 1)'(mem_depth(i_sel));
    assign o_we   = r_we;
    assign o_addr = r_addr;
    assign o_data = r_data;
    assign o_err  = r_err;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we   <= '0;
            r_addr <= '0;
            r_data <= '0;
            r_err  <= 1'b0;
        end else begin
            r_we  <= (i_fire && w_ok) ? 4'd1 << i_sel : 4'd0;
            r_err <= i_fire && !w_ok;
            if (i_fire) begin
                r_addr <= i_addr;
                r_data <= i_data;
            end
        end
    end
endmodule

// File: rtl/rnn_seq_ctrl.sv
// rnn_seq_ctrl: timestep sequencer and config arbiter for the 3-in/4-hidden/2-out RNN.
// Optional SEQ_TIMEOUT_EN aborts a stalled sequence and adds the err_timeout port.
module rnn_seq_ctrl #(
    parameter int DATA_W    = 18,
    parameter int NUM_STEPS = 4,
    parameter int STEP_W    = 2,
    parameter int CFG_AW    = 7
`ifdef SEQ_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 255
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3*DATA_W-1:0] in_u,
    output logic [3*DATA_W-1:0] dp_u,
    output logic                dp_en,
    output logic                dp_first,
    output logic [STEP_W-1:0]   dp_step,
    input  logic [2*DATA_W-1:0] dp_y,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*DATA_W-1:0] out_y,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [1:0]          cfg_sel,
    input  logic [CFG_AW-1:0]   cfg_addr,
    input  logic [DATA_W-1:0]   cfg_data,
    output logic [3:0]          mem_we,
    output logic [CFG_AW-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_data,
    output logic                cfg_err,
`ifdef SEQ_TIMEOUT_EN
    output logic                err_timeout,
`endif
    output logic [15:0]         seq_done_cnt
);
    import rnn_pkg::*;
    state_t              r_state, w_state_nxt;
    logic [STEP_W-1:0]   r_cnt, w_cnt_nxt;
    logic [2*DATA_W-1:0] r_out_y;
    logic [15:0]         r_done_cnt;
    logic                w_idle, w_hs, w_last, w_timeout;
    assign w_idle       = r_state == IDLE;
    assign cfg_ready    = w_idle && cfg_valid;
    assign in_ready     = (w_idle && !cfg_valid) || r_state == STEP;
    assign w_hs         = in_valid && in_ready;
    assign w_last       = r_cnt == STEP_W'(NUM_STEPS - 1);
    assign dp_en        = w_hs;
    assign dp_first     = w_hs && w_idle;
    assign dp_step      = (w_hs && !w_idle) ? r_cnt : '0;
    assign dp_u         = in_u;
    assign out_valid    = r_state == OUT;
    assign out_y        = r_out_y;
    assign seq_done_cnt = r_done_cnt;
`ifdef SEQ_TIMEOUT_EN
    // Counts consecutive stall cycles in STEP; any handshake restarts it.
    logic [7:0] r_idle_cnt;
    logic       r_err_timeout;
    assign w_timeout   = r_state == STEP && !w_hs && r_idle_cnt == 8'(TIMEOUT_CYC - 1);
    assign err_timeout = r_err_timeout;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idle_cnt    <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_idle_cnt    <= (r_state != STEP || w_hs || w_timeout) ? 8'd0 : r_idle_cnt + 8'd1;
            r_err_timeout <= w_timeout;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: if (w_hs) begin
                w_state_nxt = NUM_STEPS == 1 ? CAPTURE : STEP;
                w_cnt_nxt   = NUM_STEPS == 1 ? '0 : STEP_W'(1);
            end
            STEP: if (w_hs) begin
                w_state_nxt = w_last ? CAPTURE : STEP;
                w_cnt_nxt   = w_last ? '0 : r_cnt + 1'b1;
            end else if (w_timeout) begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
            CAPTURE: w_state_nxt = OUT;
            OUT: if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end
    // dp_y is valid in CAPTURE because the final x update landed on the previous edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_out_y    <= '0;
            r_done_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (r_state == CAPTURE) begin
                r_out_y    <= dp_y;
                r_done_cnt <= r_done_cnt + 16'd1;
            end
        end
    end
    rnn_cfg_decode #(.DATA_W(DATA_W), .CFG_AW(CFG_AW)) u_cfg (
        .clk    (clk),
        .reset  (reset),
        .i_fire (cfg_valid && cfg_ready),
        .i_sel  (cfg_sel),
        .i_addr (cfg_addr),
        .i_data (cfg_data),
        .o_we   (mem_we),
        .o_addr (mem_addr),
        .o_data (mem_data),
        .o_err  (cfg_err)
    );
endmodule
